// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types for the ALU sequencer and its command driver.
//   opcode_e     - ALU operation encoding (shared with alu_seq)
//   drv_state_e  - alu_driver control FSM states
//   alu_cmd_t    - one queued command: opcode plus two signed operands
//   ALU_DRV_DEPTH - default command FIFO depth
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        MULT = 2'd2,
        DIV  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } drv_state_e;

    localparam int ALU_DRV_DEPTH = 4;
    localparam int OPND_W        = 8;
    localparam int RES_W         = 9;

    typedef struct packed {
        opcode_e                   opcode;
        logic signed [OPND_W-1:0]  op1;
        logic signed [OPND_W-1:0]  op2;
    } alu_cmd_t;

    // A divide by zero is resolved by the driver itself and never reaches the ALU.
    function automatic logic is_div_zero(alu_cmd_t c);
        return (c.opcode == DIV) && (c.op2 == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Synchronous FIFO of alu_cmd_t entries, first-word-fall-through read.
//   clk, rst_n  - clock, asynchronous active-low reset (pointers only)
//   push, din   - write request and data; ignored while full
//   pop, dout   - read request; dout always shows the head entry
//   full, empty - occupancy flags, functions of the pointers only
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = ALU_DRV_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t din,
    output alu_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    alu_cmd_t    mem_q [DEPTH];
    alu_cmd_t    mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle never frees room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_driver.sv
// alu_driver
// Queues commands, sequences them one at a time through the registered ALU
// (alu_seq) and returns each result on a valid/ready response channel.
//   clk, rst            - clock, asynchronous active-low reset
//   cmd_*               - upstream command handshake (valid/ready, opcode, operands)
//   alu_opcode/operand* - ALU inputs, idle at ADD 0,0 outside ISSUE
//   alu_rst             - ALU reset, held until the first edge after rst releases
//   alu_out             - registered ALU result
//   rsp_*               - response handshake; rsp_dz flags divide-by-zero
module alu_driver
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = ALU_DRV_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  opcode_e                  cmd_opcode,
    input  logic signed [OPND_W-1:0] cmd_op1,
    input  logic signed [OPND_W-1:0] cmd_op2,
    output opcode_e                  alu_opcode,
    output logic signed [OPND_W-1:0] alu_operand1,
    output logic signed [OPND_W-1:0] alu_operand2,
    output logic                     alu_rst,
    input  logic signed [RES_W-1:0]  alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [RES_W-1:0]  rsp_result,
    output opcode_e                  rsp_opcode,
    output logic                     rsp_dz
);

    drv_state_e               state_q, state_d;
    alu_cmd_t                 issue_q, issue_d;
    logic signed [RES_W-1:0]  rsp_result_q, rsp_result_d;
    opcode_e                  rsp_opcode_q, rsp_opcode_d;
    logic                     rsp_dz_q, rsp_dz_d;
    logic                     alu_rst_q, alu_rst_d;

    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    alu_cmd_t fifo_din;
    alu_cmd_t fifo_dout;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_din  = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        rsp_result_d = rsp_result_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_dz_d     = rsp_dz_q;
        fifo_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    issue_d  = fifo_dout;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Divide-by-zero skips the ALU and answers directly.
                if (is_div_zero(issue_q)) begin
                    rsp_result_d = '0;
                    rsp_opcode_d = DIV;
                    rsp_dz_d     = 1'b1;
                    state_d      = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_result_d = alu_out;
                rsp_opcode_d = issue_q.opcode;
                rsp_dz_d     = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU inputs are driven only while a real operation is being issued.
    always_comb begin
        alu_opcode   = ADD;
        alu_operand1 = '0;
        alu_operand2 = '0;
        if ((state_q == ISSUE) && !is_div_zero(issue_q)) begin
            alu_opcode   = issue_q.opcode;
            alu_operand1 = issue_q.op1;
            alu_operand2 = issue_q.op2;
        end
    end

    // alu_rst falls on the first edge after reset release.
    assign alu_rst_d = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rsp_result_q <= '0;
            rsp_opcode_q <= ADD;
            rsp_dz_q     <= 1'b0;
            alu_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_dz_q     <= rsp_dz_d;
            alu_rst_q    <= alu_rst_d;
        end
    end

    // The issue register is only read in ISSUE/CAPTURE, which always follow a load.
    always_ff @(posedge clk) begin
        issue_q <= issue_d;
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_opcode = rsp_opcode_q;
    assign rsp_dz     = rsp_dz_q;
    assign alu_rst    = alu_rst_q;

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;
    import alu_seq_pkg::*;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    opcode_e           cmd_opcode;
    logic signed [7:0] cmd_op1;
    logic signed [7:0] cmd_op2;
    opcode_e           alu_opcode;
    logic signed [7:0] alu_operand1;
    logic signed [7:0] alu_operand2;
    logic              alu_rst;
    logic signed [8:0] alu_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic signed [8:0] rsp_result;
    opcode_e           rsp_opcode;
    logic              rsp_dz;

    int n_checks = 0;
    int n_pass   = 0;
    int alu_bad  = 0;
    logic mon_en = 1'b0;

    alu_driver #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_op1      (cmd_op1),
        .cmd_op2      (cmd_op2),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_rst      (alu_rst),
        .alu_out      (alu_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_opcode   (rsp_opcode),
        .rsp_dz       (rsp_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 8x8 signed operation, result wrapped to 9 bits.
    function automatic logic signed [8:0] ref_alu(opcode_e op, logic signed [7:0] a, logic signed [7:0] b);
        logic signed [15:0] a16;
        logic signed [15:0] b16;
        logic signed [15:0] w;
        a16 = 16'(a);
        b16 = 16'(b);
        case (op)
            ADD:     w = a16 + b16;
            SUB:     w = a16 - b16;
            MULT:    w = a16 * b16;
            default: w = (b16 == 16'sd0) ? 16'sd0 : a16 / b16;
        endcase
        return w[8:0];
    endfunction

    // Behavioural stand-in for alu_seq: registered result, synchronous alu_rst.
    always @(posedge clk) begin
        if (alu_rst) alu_out <= '0;
        else         alu_out <= ref_alu(alu_opcode, alu_operand1, alu_operand2);
    end

    always @(negedge clk) begin
        if (mon_en && alu_opcode != ADD) alu_bad++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input opcode_e op, input logic signed [7:0] a, input logic signed [7:0] b);
        cmd_opcode = op;
        cmd_op1    = a;
        cmd_op2    = b;
        cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic get_rsp(input string tag, input int exp_res, input opcode_e exp_op, input int exp_dz);
        int e;
        wait_rsp(e);
        check({tag, "_valid"}, int'(rsp_valid), 1);
        check({tag, "_res"}, int'(rsp_result), exp_res);
        check({tag, "_op"}, int'(rsp_opcode), int'(exp_op));
        check({tag, "_dz"}, int'(rsp_dz), exp_dz);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_drop"}, int'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int idx;
        logic acc;
        opcode_e           t_op [6];
        logic signed [7:0] t_a  [6];
        logic signed [7:0] t_b  [6];
        int                t_r  [5];

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = ADD;
        cmd_op1    = '0;
        cmd_op2    = '0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        check("rst_rsp_opcode", int'(rsp_opcode), int'(ADD));
        check("rst_rsp_dz", int'(rsp_dz), 0);
        check("rst_alu_rst", int'(alu_rst), 1);
        check("rst_alu_opcode", int'(alu_opcode), int'(ADD));
        check("rst_alu_op1", int'(alu_operand1), 0);
        rst = 1'b1;
        @(negedge clk);
        check("alu_rst_release", int'(alu_rst), 0);

        // ADD 5,-3 : latency 3, result 2
        send(ADD, 8'sd5, -8'sd3);
        wait_rsp(e);
        check("add_lat", e, 3);
        check("add_res", int'(rsp_result), 2);
        check("add_op", int'(rsp_opcode), int'(ADD));
        check("add_dz", int'(rsp_dz), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("add_drop", int'(rsp_valid), 0);

        // MULT then SUB, back to back
        send(MULT, 8'sd10, -8'sd12);
        send(SUB, -8'sd128, 8'sd127);
        get_rsp("mult", -120, MULT, 0);
        get_rsp("sub", -255, SUB, 0);

        // DIV by zero: latency 2, ALU never sees DIV
        repeat (2) @(negedge clk);
        alu_bad = 0;
        mon_en  = 1'b1;
        send(DIV, 8'sd7, 8'sd0);
        wait_rsp(e);
        check("dz_lat", e, 2);
        check("dz_res", int'(rsp_result), 0);
        check("dz_flag", int'(rsp_dz), 1);
        check("dz_op", int'(rsp_opcode), int'(DIV));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        check("dz_alu_idle", alu_bad, 0);

        // Backpressure: 6 offered, 5 accepted
        t_op = '{ADD, SUB, MULT, DIV, ADD, ADD};
        t_a  = '{8'sd1, 8'sd3, 8'sd127, -8'sd100, 8'sd127, 8'sd0};
        t_b  = '{8'sd2, 8'sd10, 8'sd127, 8'sd7, 8'sd127, 8'sd0};
        t_r  = '{3, -7, -255, -14, 254};
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            acc = 1'b0;
            if (idx < 6) begin
                cmd_opcode = t_op[idx];
                cmd_op1    = t_a[idx];
                cmd_op2    = t_b[idx];
                cmd_valid  = 1'b1;
                acc        = cmd_ready;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) idx++;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", idx, 5);
        check("bp_cmd_ready", int'(cmd_ready), 0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(e);
            check("bp_valid", int'(rsp_valid), 1);
            check("bp_res", int'(rsp_result), t_r[k]);
            check("bp_op", int'(rsp_opcode), int'(t_op[k]));
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_drained", int'(rsp_valid), 0);

        // Reset during CAPTURE
        send(DIV, 8'sd100, 8'sd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", int'(rsp_valid), 0);
        check("mid_rst_alu_rst", int'(alu_rst), 1);
        @(negedge clk);
        rst = 1'b1;
        e = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) e++;
        end
        check("mid_rst_no_rsp", e, 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        check("mid_rst_alu_rst_rel", int'(alu_rst), 0);

        // Random commands with random rsp_ready
        begin
            int                exp_r [$];
            opcode_e           exp_o [$];
            int                exp_d [$];
            fork
                begin
                    opcode_e op;
                    logic signed [7:0] a;
                    logic signed [7:0] b;
                    int tries;
                    for (int i = 0; i < 20; i++) begin
                        op = opcode_e'($urandom_range(0, 3));
                        a  = 8'($urandom);
                        b  = (i % 5 == 0) ? 8'sd0 : 8'($urandom);
                        cmd_opcode = op;
                        cmd_op1    = a;
                        cmd_op2    = b;
                        cmd_valid  = 1'b1;
                        tries = 0;
                        acc   = 1'b0;
                        while (!acc && tries < 200) begin
                            acc = cmd_ready;
                            @(posedge clk);
                            @(negedge clk);
                            tries++;
                        end
                        if (acc) begin
                            exp_r.push_back((op == DIV && b == 0) ? 0 : int'(ref_alu(op, a, b)));
                            exp_o.push_back(op);
                            exp_d.push_back((op == DIV && b == 0) ? 1 : 0);
                        end
                    end
                    cmd_valid = 1'b0;
                end
                begin
                    int got;
                    int cyc;
                    logic hold;
                    logic signed [8:0] pr;
                    opcode_e po;
                    logic pd;
                    got  = 0;
                    cyc  = 0;
                    hold = 1'b0;
                    pr   = '0;
                    po   = ADD;
                    pd   = 1'b0;
                    while (got < 20 && cyc < 3000) begin
                        @(negedge clk);
                        cyc++;
                        if (hold) begin
                            check("rnd_hold_valid", int'(rsp_valid), 1);
                            check("rnd_hold_res", int'(rsp_result), int'(pr));
                            check("rnd_hold_op", int'(rsp_opcode), int'(po));
                            check("rnd_hold_dz", int'(rsp_dz), int'(pd));
                        end
                        rsp_ready = 1'($urandom_range(0, 1));
                        hold = 1'b0;
                        if (rsp_valid) begin
                            if (rsp_ready) begin
                                if (exp_r.size() == 0) begin
                                    check("rnd_extra", 1, 0);
                                end else begin
                                    check("rnd_res", int'(rsp_result), exp_r.pop_front());
                                    check("rnd_op", int'(rsp_opcode), int'(exp_o.pop_front()));
                                    check("rnd_dz", int'(rsp_dz), exp_d.pop_front());
                                end
                                got++;
                            end else begin
                                hold = 1'b1;
                                pr   = rsp_result;
                                po   = rsp_opcode;
                                pd   = rsp_dz;
                            end
                        end
                    end
                    check("rnd_count", got, 20);
                end
            join
        end
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
